full_handshake_rx: RTL



---
 rtl/full_handshake_rx_pkg.sv | 18 +
 rtl/sync_2ff.sv | 22 ++
 rtl/full_handshake_rx.sv | 117 +++++++++++
 3 files changed

// File: rtl/full_handshake_rx_pkg.sv
// Shared types for the receive end of the four-phase req/ack crossing.
// Holds the debug view of the receiver and the output-slot helper.
package full_handshake_rx_pkg;

  // Debug snapshot of the receiver control path.
  typedef struct packed {
    logic [1:0] state;
    logic       req_sync;
    logic       slot_free;
    logic       capture;
  } rx_dbg_t;

  // The output register can take a new word if it is empty or draining now.
  function automatic logic calc_slot_free(input logic valid, input logic ready);
    return !valid || ready;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level signal.
// Resets to 0; reusable on either end of the req/ack crossing.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/full_handshake_rx.sv
// Receive end of the four-phase req/ack crossing: synchronises req, captures
// the held data word into a one-entry valid/ready register, returns ack.
module full_handshake_rx
  import full_handshake_rx_pkg::*;
#(
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_i,
  input  logic [DW-1:0] req_data_i,
  output logic          ack_o,
  output logic          recv_valid_o,
  input  logic          recv_ready_i,
  output logic [DW-1:0] recv_data_o,
  output rx_dbg_t       dbg
);

  localparam logic [1:0] ST_IDLE   = 2'b01;
  localparam logic [1:0] ST_ASSERT = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    ASSERT = ST_ASSERT
  } state_e;

  // Handshake: a word moves to the consumer on every clk edge where
  // recv_valid_o && recv_ready_i; recv_data_o is stable while valid is high
  // and ready is not yet seen. Across the crossing, ack_o rises only once the
  // word is captured and falls only after the synchronised req has dropped.

  state_e        state;
  state_e        state_nxt;
  logic          req;
  logic          slot_free;
  logic          capture;
  logic          ack_nxt;
  logic          valid_nxt;
  logic [DW-1:0] data_nxt;

  sync_2ff u_req_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (req_i),
    .q     (req)
  );

  assign slot_free = calc_slot_free(recv_valid_o, recv_ready_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    ack_nxt   = ack_o;
    case (state)
      IDLE: begin
        ack_nxt = 1'b0;
        if (req && slot_free) begin
          capture   = 1'b1;
          ack_nxt   = 1'b1;
          state_nxt = ASSERT;
        end
      end
      ASSERT: begin
        ack_nxt = 1'b1;
        if (!req) begin
          ack_nxt   = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: begin
        ack_nxt   = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Capture takes priority over a drain on the same edge, so no bubble.
  always_comb begin
    valid_nxt = recv_valid_o;
    data_nxt  = recv_data_o;
    if (capture) begin
      valid_nxt = 1'b1;
      data_nxt  = req_data_i;
    end else if (recv_valid_o && recv_ready_i) begin
      valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_o        <= 1'b0;
      recv_valid_o <= 1'b0;
      recv_data_o  <= '0;
    end else begin
      ack_o        <= ack_nxt;
      recv_valid_o <= valid_nxt;
      recv_data_o  <= data_nxt;
    end
  end

  always_comb begin
    dbg           = '0;
    dbg.state     = state;
    dbg.req_sync  = req;
    dbg.slot_free = slot_free;
    dbg.capture   = capture;
  end

endmodule
